wt_dcache_rd_ctrl: RTL and testbench

// Read controller for one load port (LD unit or PTW) of the write-through L1 dcache; one instance per read port.

---
 rtl/wt_dcache_rd_ctrl_pkg.sv | 54 +++++
 rtl/wt_dcache_rd_ctrl.sv | 154 +++++++++++++++
 tb/tb_wt_dcache_rd_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/wt_dcache_rd_ctrl_pkg.sv
// wt_dcache_rd_ctrl_pkg: cache geometry, port structs, cacheable-region map and FSM states for the dcache read controller
package wt_dcache_rd_ctrl_pkg;
   localparam int unsigned PLEN                = 56;
   localparam int unsigned DCACHE_INDEX_WIDTH  = 12;
   localparam int unsigned DCACHE_TAG_WIDTH    = PLEN - DCACHE_INDEX_WIDTH;
   localparam int unsigned DCACHE_OFFSET_WIDTH = 4;
   localparam int unsigned DCACHE_CL_IDX_WIDTH = DCACHE_INDEX_WIDTH - DCACHE_OFFSET_WIDTH;
   localparam int unsigned DCACHE_SET_ASSOC    = 8;
   localparam int unsigned CACHE_ID_WIDTH      = 2;
   localparam int unsigned NR_CACHED_REGIONS   = 2;

   typedef struct packed {
      logic [DCACHE_INDEX_WIDTH-1:0] address_index;
      logic [DCACHE_TAG_WIDTH-1:0]   address_tag;
      logic [63:0]                   data_wdata;
      logic                          data_req;
      logic                          data_we;
      logic [7:0]                    data_be;
      logic [1:0]                    data_size;
      logic                          kill_req;
      logic                          tag_valid;
   } dcache_req_i_t;

   typedef struct packed {
      logic        data_gnt;
      logic        data_rvalid;
      logic [63:0] data_rdata;
   } dcache_req_o_t;

   typedef struct packed {
      logic [NR_CACHED_REGIONS-1:0][63:0] cached_region_addr_base;
      logic [NR_CACHED_REGIONS-1:0][63:0] cached_region_length;
   } ariane_cfg_t;

   // a zero-length region never matches, so unused slots stay zero
   localparam ariane_cfg_t ArianeDefaultConfig = '{
      cached_region_addr_base: {64'h0, 64'h8000_0000},
      cached_region_length:    {64'h0, 64'h4000_0000}
   };

   typedef enum logic [2:0] {
      IDLE, READ, MISS_REQ, MISS_WAIT, KILL_MISS, KILL_MISS_ACK, REPLAY_REQ, REPLAY_READ
   } rd_state_e;

   function automatic logic is_inside_cacheable_regions(ariane_cfg_t cfg, logic [PLEN-1:0] addr);
      logic [63:0] a;
      a = 64'(addr);
      is_inside_cacheable_regions = 1'b0;
      for (int i = 0; i < NR_CACHED_REGIONS; i++)
         if (a >= cfg.cached_region_addr_base[i] &&
             a < cfg.cached_region_addr_base[i] + cfg.cached_region_length[i])
            is_inside_cacheable_regions = 1'b1;
   endfunction
endpackage

// File: rtl/wt_dcache_rd_ctrl.sv
// wt_dcache_rd_ctrl: read controller for one load port of the write-through L1 dcache
// clk_i/rst_ni/clr_i  clock, async active-low reset, sync clear to IDLE
// cache_en_i/busy_o   cache enable (0 = all misses non-cacheable), controller busy
// req_port_i/o        core load request (index/tag phase, kill) and grant/rvalid/rdata
// miss_*              refill / non-cacheable request handshake to the miss unit
// rd_*                cache memory read port (index phase request, tag phase results)
module wt_dcache_rd_ctrl
   import wt_dcache_rd_ctrl_pkg::*;
#(
   parameter logic [CACHE_ID_WIDTH-1:0] RdTxId    = 1,
   parameter ariane_cfg_t               ArianeCfg = ArianeDefaultConfig
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic                           clr_i,
   input  logic                           cache_en_i,
   output logic                           busy_o,
   input  dcache_req_i_t                  req_port_i,
   output dcache_req_o_t                  req_port_o,
   output logic                           miss_req_o,
   input  logic                           miss_ack_i,
   output logic                           miss_we_o,
   output logic [63:0]                    miss_wdata_o,
   output logic [CACHE_ID_WIDTH-1:0]      miss_id_o,
   output logic [DCACHE_SET_ASSOC-1:0]    miss_vld_bits_o,
   output logic [PLEN-1:0]                miss_paddr_o,
   output logic                           miss_nc_o,
   output logic [2:0]                     miss_size_o,
   input  logic                           miss_replay_i,
   input  logic                           miss_rtrn_vld_i,
   input  logic                           wr_cl_vld_i,
   output logic [DCACHE_TAG_WIDTH-1:0]    rd_tag_o,
   output logic [DCACHE_CL_IDX_WIDTH-1:0] rd_idx_o,
   output logic [DCACHE_OFFSET_WIDTH-1:0] rd_off_o,
   output logic                           rd_req_o,
   output logic                           rd_tag_only_o,
   input  logic                           rd_ack_i,
   input  logic [63:0]                    rd_data_i,
   input  logic [DCACHE_SET_ASSOC-1:0]    rd_vld_bits_i,
   input  logic [DCACHE_SET_ASSOC-1:0]    rd_hit_oh_i
);
   rd_state_e                     state_q, state_d;
   logic [DCACHE_INDEX_WIDTH-1:0] idx_q, idx_d, rd_addr;
   logic [DCACHE_TAG_WIDTH-1:0]   tag_q, tag_d;
   logic [1:0]                    size_q, size_d;
   logic [DCACHE_SET_ASSOC-1:0]   vld_q, vld_d;
   logic                          rd_ack_q, gnt, rvalid, new_req, save_tag, hit;
   logic                          unused_req;

   assign unused_req = ^{req_port_i.data_wdata, req_port_i.data_we, req_port_i.data_be};
   assign hit        = |rd_hit_oh_i & cache_en_i;
   assign save_tag   = state_q == READ && req_port_i.tag_valid;
   assign idx_d      = gnt ? req_port_i.address_index : idx_q;
   assign size_d     = gnt ? req_port_i.data_size : size_q;
   assign tag_d      = save_tag ? req_port_i.address_tag : tag_q;
   // a newly offered request drives the index directly so it can be granted this cycle
   assign rd_addr    = new_req ? req_port_i.address_index : idx_q;
   assign rd_idx_o   = rd_addr[DCACHE_INDEX_WIDTH-1:DCACHE_OFFSET_WIDTH];
   assign rd_off_o   = rd_addr[DCACHE_OFFSET_WIDTH-1:0];
   assign rd_tag_o   = tag_d;
   assign rd_tag_only_o   = 1'b0;
   assign miss_we_o       = 1'b0;
   assign miss_wdata_o    = '0;
   assign miss_id_o       = RdTxId;
   assign miss_vld_bits_o = vld_q;
   assign miss_paddr_o    = {tag_q, idx_q};
   assign miss_nc_o       = ~cache_en_i | ~is_inside_cacheable_regions(ArianeCfg, miss_paddr_o);
   assign miss_size_o     = miss_nc_o ? {1'b0, size_q} : 3'b111;
   assign busy_o          = state_q != IDLE;
   assign req_port_o      = '{data_gnt: gnt, data_rvalid: rvalid, data_rdata: rd_data_i};

   always_comb begin
      state_d    = state_q;
      vld_d      = vld_q;
      gnt        = 1'b0;
      rvalid     = 1'b0;
      new_req    = 1'b0;
      rd_req_o   = 1'b0;
      miss_req_o = 1'b0;
      case (state_q)
         IDLE: if (req_port_i.data_req) begin
            rd_req_o = 1'b1;
            new_req  = 1'b1;
            gnt      = rd_ack_i;
            state_d  = rd_ack_i ? READ : IDLE;
         end
         READ, REPLAY_READ: begin
            rd_req_o = 1'b1;
            if (req_port_i.kill_req) begin
               rvalid  = 1'b1;
               state_d = IDLE;
            end else if (req_port_i.tag_valid || state_q == REPLAY_READ) begin
               // tag-phase data is unreliable if the readout mux was taken or the index phase was not acked
               if (wr_cl_vld_i || !rd_ack_q) state_d = REPLAY_REQ;
               else if (hit) begin
                  rvalid  = 1'b1;
                  new_req = req_port_i.data_req;
                  gnt     = req_port_i.data_req & rd_ack_i;
                  state_d = gnt ? READ : IDLE;
               end else begin
                  vld_d   = rd_vld_bits_i;
                  state_d = MISS_REQ;
               end
            end
         end
         MISS_REQ: begin
            miss_req_o = 1'b1;
            if (req_port_i.kill_req) begin
               rvalid  = 1'b1;
               state_d = miss_ack_i ? KILL_MISS : KILL_MISS_ACK;
            end else if (miss_replay_i) state_d = REPLAY_REQ;
            else if (miss_ack_i) state_d = MISS_WAIT;
         end
         MISS_WAIT: if (req_port_i.kill_req) begin
            rvalid  = 1'b1;
            state_d = miss_rtrn_vld_i ? IDLE : KILL_MISS;
         end else if (miss_rtrn_vld_i) begin
            rvalid  = 1'b1;
            state_d = IDLE;
         end
         REPLAY_REQ: begin
            rd_req_o = 1'b1;
            if (req_port_i.kill_req) begin
               rvalid  = 1'b1;
               state_d = IDLE;
            end else if (rd_ack_i) state_d = REPLAY_READ;
         end
         KILL_MISS_ACK: begin
            miss_req_o = 1'b1;
            if (miss_replay_i) state_d = IDLE;
            else if (miss_ack_i) state_d = KILL_MISS;
         end
         KILL_MISS: if (miss_rtrn_vld_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni)
      if (!rst_ni) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         tag_q    <= '0;
         size_q   <= '0;
         vld_q    <= '0;
         rd_ack_q <= 1'b0;
      end else begin
         state_q  <= clr_i ? IDLE : state_d;
         idx_q    <= idx_d;
         tag_q    <= tag_d;
         size_q   <= size_d;
         vld_q    <= vld_d;
         rd_ack_q <= rd_ack_i;
      end
endmodule

// File: tb/tb_wt_dcache_rd_ctrl.sv
// tb_wt_dcache_rd_ctrl: directed self-checking bench for the dcache read controller
module tb_wt_dcache_rd_ctrl;
   import wt_dcache_rd_ctrl_pkg::*;
   logic clk_i = 1'b0, rst_ni = 1'b0, clr_i = 1'b0, cache_en_i = 1'b1;
   logic busy_o, miss_req_o, miss_ack_i = 1'b0, miss_we_o, miss_nc_o;
   logic miss_replay_i = 1'b0, miss_rtrn_vld_i = 1'b0, wr_cl_vld_i = 1'b0;
   logic rd_req_o, rd_tag_only_o, rd_ack_i = 1'b1;
   logic [63:0] miss_wdata_o, rd_data_i = '0;
   logic [CACHE_ID_WIDTH-1:0] miss_id_o;
   logic [DCACHE_SET_ASSOC-1:0] miss_vld_bits_o, rd_vld_bits_i = '0, rd_hit_oh_i = '0;
   logic [PLEN-1:0] miss_paddr_o;
   logic [2:0] miss_size_o;
   logic [DCACHE_TAG_WIDTH-1:0] rd_tag_o;
   logic [DCACHE_CL_IDX_WIDTH-1:0] rd_idx_o;
   logic [DCACHE_OFFSET_WIDTH-1:0] rd_off_o;
   dcache_req_i_t r = '0;
   dcache_req_o_t o;
   int total = 0, bad = 0;

   wt_dcache_rd_ctrl dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clr_i(clr_i), .cache_en_i(cache_en_i), .busy_o(busy_o),
      .req_port_i(r), .req_port_o(o), .miss_req_o(miss_req_o), .miss_ack_i(miss_ack_i),
      .miss_we_o(miss_we_o), .miss_wdata_o(miss_wdata_o), .miss_id_o(miss_id_o),
      .miss_vld_bits_o(miss_vld_bits_o), .miss_paddr_o(miss_paddr_o), .miss_nc_o(miss_nc_o),
      .miss_size_o(miss_size_o), .miss_replay_i(miss_replay_i), .miss_rtrn_vld_i(miss_rtrn_vld_i),
      .wr_cl_vld_i(wr_cl_vld_i), .rd_tag_o(rd_tag_o), .rd_idx_o(rd_idx_o), .rd_off_o(rd_off_o),
      .rd_req_o(rd_req_o), .rd_tag_only_o(rd_tag_only_o), .rd_ack_i(rd_ack_i), .rd_data_i(rd_data_i),
      .rd_vld_bits_i(rd_vld_bits_i), .rd_hit_oh_i(rd_hit_oh_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc;
      @(posedge clk_i);
      #1;
   endtask

   task automatic issue(input logic [11:0] idx, input logic [43:0] tag, input logic [1:0] size);
      cyc;
      r.data_req = 1'b1;
      r.address_index = idx;
      r.address_tag = tag;
      r.data_size = size;
      #1;
      chk("gnt", o.data_gnt, 1);
      chk("gnt_rd_req", rd_req_o, 1);
   endtask

   initial begin
      #12;
      chk("rst_busy", busy_o, 0);
      chk("rst_gnt", o.data_gnt, 0);
      chk("rst_rvalid", o.data_rvalid, 0);
      chk("rst_miss_req", miss_req_o, 0);
      chk("rst_rd_req", rd_req_o, 0);
      rst_ni = 1'b1;
      // hit
      issue(12'h040, 44'h80000, 2'd3);
      chk("hit_rd_idx", rd_idx_o, 8'h04);
      chk("hit_rd_off", rd_off_o, 0);
      cyc; r.data_req = 0; r.tag_valid = 1; rd_hit_oh_i = 8'h01; rd_data_i = 64'hDEAD; #1;
      chk("hit_rvalid", o.data_rvalid, 1);
      chk("hit_rdata", o.data_rdata, 64'hDEAD);
      chk("hit_rd_tag", rd_tag_o, 44'h80000);
      cyc; r.tag_valid = 0; rd_hit_oh_i = 0; #1;
      chk("hit_idle", busy_o, 0);
      chk("hit_single_rvalid", o.data_rvalid, 0);
      // cacheable miss
      issue(12'h080, 44'h80000, 2'd3);
      cyc; r.data_req = 0; r.tag_valid = 1; rd_vld_bits_i = 8'h0F; #1;
      chk("miss_no_rvalid", o.data_rvalid, 0);
      cyc; r.tag_valid = 0; rd_vld_bits_i = 0; #1;
      chk("miss_req", miss_req_o, 1);
      chk("miss_size", miss_size_o, 3'b111);
      chk("miss_nc", miss_nc_o, 0);
      chk("miss_paddr", miss_paddr_o, 56'h8000_0080);
      chk("miss_vld", miss_vld_bits_o, 8'h0F);
      chk("miss_id", miss_id_o, 1);
      chk("miss_we", miss_we_o, 0);
      cyc; miss_ack_i = 1; #1;
      chk("miss_req_held", miss_req_o, 1);
      cyc; miss_ack_i = 0; #1;
      chk("miss_wait_req", miss_req_o, 0);
      chk("miss_wait_busy", busy_o, 1);
      chk("miss_wait_rvalid", o.data_rvalid, 0);
      cyc; miss_rtrn_vld_i = 1; rd_data_i = 64'hBEEF; #1;
      chk("miss_rvalid", o.data_rvalid, 1);
      chk("miss_rdata", o.data_rdata, 64'hBEEF);
      cyc; miss_rtrn_vld_i = 0; #1;
      chk("miss_idle", busy_o, 0);
      // non-cacheable via cache disable, hit ignored
      cache_en_i = 0;
      issue(12'h0C4, 44'h80000, 2'd2);
      cyc; r.data_req = 0; r.tag_valid = 1; rd_hit_oh_i = 8'h01; #1;
      chk("nc_hit_ignored", o.data_rvalid, 0);
      cyc; r.tag_valid = 0; rd_hit_oh_i = 0; miss_ack_i = 1; #1;
      chk("nc_flag", miss_nc_o, 1);
      chk("nc_size", miss_size_o, 3'b010);
      cyc; miss_ack_i = 0; miss_rtrn_vld_i = 1; rd_data_i = 64'h1234; #1;
      chk("nc_rvalid", o.data_rvalid, 1);
      chk("nc_rdata", o.data_rdata, 64'h1234);
      cyc; miss_rtrn_vld_i = 0; cache_en_i = 1; #1;
      chk("nc_idle", busy_o, 0);
      // kill in MISS_WAIT
      issue(12'h100, 44'h80000, 2'd3);
      cyc; r.data_req = 0; r.tag_valid = 1; #1;
      cyc; r.tag_valid = 0; miss_ack_i = 1; #1;
      cyc; miss_ack_i = 0; r.kill_req = 1; #1;
      chk("kill_rvalid", o.data_rvalid, 1);
      cyc; r.kill_req = 0; #1;
      chk("kill_busy", busy_o, 1);
      chk("kill_no_rvalid", o.data_rvalid, 0);
      cyc; #1;
      chk("kill_busy2", busy_o, 1);
      cyc; miss_rtrn_vld_i = 1; #1;
      chk("kill_no_second_rvalid", o.data_rvalid, 0);
      cyc; miss_rtrn_vld_i = 0; #1;
      chk("kill_idle", busy_o, 0);
      // readout collision replay
      issue(12'h140, 44'h80000, 2'd3);
      cyc; r.data_req = 0; r.tag_valid = 1; rd_hit_oh_i = 8'h02; wr_cl_vld_i = 1; #1;
      chk("coll_no_rvalid", o.data_rvalid, 0);
      cyc; r.tag_valid = 0; rd_hit_oh_i = 0; wr_cl_vld_i = 0; #1;
      chk("coll_rd_req", rd_req_o, 1);
      chk("coll_rd_idx", rd_idx_o, 8'h14);
      chk("coll_rd_tag", rd_tag_o, 44'h80000);
      chk("coll_rvalid0", o.data_rvalid, 0);
      cyc; rd_hit_oh_i = 8'h02; rd_data_i = 64'hCAFE; #1;
      chk("coll_rvalid", o.data_rvalid, 1);
      chk("coll_rdata", o.data_rdata, 64'hCAFE);
      cyc; rd_hit_oh_i = 0; #1;
      chk("coll_idle", busy_o, 0);
      chk("coll_single_rvalid", o.data_rvalid, 0);
      // miss replay from miss unit
      issue(12'h180, 44'h80000, 2'd3);
      cyc; r.data_req = 0; r.tag_valid = 1; #1;
      cyc; r.tag_valid = 0; miss_replay_i = 1; #1;
      chk("mrep_req", miss_req_o, 1);
      cyc; miss_replay_i = 0; #1;
      chk("mrep_rd_req", rd_req_o, 1);
      chk("mrep_no_miss_req", miss_req_o, 0);
      cyc; #1;
      chk("mrep_reread_miss", o.data_rvalid, 0);
      cyc; miss_ack_i = 1; #1;
      chk("mrep_req_again", miss_req_o, 1);
      chk("mrep_paddr", miss_paddr_o, 56'h8000_0180);
      cyc; miss_ack_i = 0; miss_rtrn_vld_i = 1; #1;
      chk("mrep_rvalid", o.data_rvalid, 1);
      cyc; miss_rtrn_vld_i = 0; #1;
      chk("mrep_idle", busy_o, 0);
      // back-to-back hit with new grant
      issue(12'h1C0, 44'h80000, 2'd3);
      cyc; r.tag_valid = 1; rd_hit_oh_i = 8'h04; r.address_index = 12'h200; #1;
      chk("b2b_rvalid", o.data_rvalid, 1);
      chk("b2b_gnt", o.data_gnt, 1);
      chk("b2b_rd_idx", rd_idx_o, 8'h20);
      cyc; r.data_req = 0; #1;
      chk("b2b_second_rvalid", o.data_rvalid, 1);
      chk("b2b_busy", busy_o, 1);
      cyc; r.tag_valid = 0; rd_hit_oh_i = 0; #1;
      chk("b2b_idle", busy_o, 0);
      // uncached region, kill before ack, then miss unit refuses
      issue(12'h040, 44'h10000, 2'd1);
      cyc; r.data_req = 0; r.tag_valid = 1; #1;
      cyc; r.tag_valid = 0; #1;
      chk("region_nc", miss_nc_o, 1);
      chk("region_size", miss_size_o, 3'b001);
      r.kill_req = 1; #1;
      chk("kmack_rvalid", o.data_rvalid, 1);
      cyc; r.kill_req = 0; #1;
      chk("kmack_req", miss_req_o, 1);
      chk("kmack_rvalid0", o.data_rvalid, 0);
      miss_replay_i = 1;
      cyc; miss_replay_i = 0; #1;
      chk("kmack_idle", busy_o, 0);
      chk("kmack_miss_req0", miss_req_o, 0);
      // synchronous clear
      issue(12'h240, 44'h80000, 2'd3);
      cyc; r.data_req = 0; clr_i = 1; #1;
      chk("clr_busy_before", busy_o, 1);
      cyc; clr_i = 0; #1;
      chk("clr_idle", busy_o, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
